// File: rtl/vram1_access_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// vram1_access_arbiter
//
// Shares the 4Kx16 VRAM1 array (two 4Kx8 SRAM halves) between the video fetch
// engine and the 68000 CPU bus. Video wins by default. A starvation counter
// forces a CPU access after CPU_STARVE_LIMIT consecutive video grants that were
// made while the CPU was waiting.
//
// SRAM timing: a strobe sampled low at edge E reads or writes at E, and read
// data is valid on i_RAM_DOUT after E. Every access therefore takes two cycles
// with the strobe low for exactly one of them, plus one cycle to capture or
// acknowledge.
//
// Ports
//   i_MCLK, i_RST_n        clock (rising edge), asynchronous active-low reset
//   i_VID_REQ/i_VID_ADDR   video read request (level) and word address
//   o_VID_ACK              1-cycle pulse: video address taken
//   o_VID_DOUT/o_VID_VALID video read data (held) and 1-cycle update pulse
//   i_CPU_REQ ... i_CPU_DIN CPU access request (level, held until DTACK),
//                          address, direction, byte strobes, write data
//   o_CPU_DOUT             CPU read data, held until the next CPU read
//   o_CPU_DTACK_n          data acknowledge, low until the CPU drops REQ
//   o_RAM_*                SRAM address, write data, strobes (all registered)
//   i_RAM_DOUT             SRAM read data {high half, low half}
// -----------------------------------------------------------------------------
module vram1_access_arbiter #(
  parameter int CPU_STARVE_LIMIT = 8
) (
  input  logic        i_MCLK,
  input  logic        i_RST_n,
  input  logic        i_VID_REQ,
  input  logic [11:0] i_VID_ADDR,
  output logic        o_VID_ACK,
  output logic [15:0] o_VID_DOUT,
  output logic        o_VID_VALID,
  input  logic        i_CPU_REQ,
  input  logic [11:0] i_CPU_ADDR,
  input  logic        i_CPU_WE,
  input  logic        i_CPU_UDS_n,
  input  logic        i_CPU_LDS_n,
  input  logic [15:0] i_CPU_DIN,
  output logic [15:0] o_CPU_DOUT,
  output logic        o_CPU_DTACK_n,
  output logic [11:0] o_RAM_ADDR,
  output logic [15:0] o_RAM_DIN,
  output logic        o_RAM_WRH_n,
  output logic        o_RAM_WRL_n,
  output logic        o_RAM_RD_n,
  input  logic [15:0] i_RAM_DOUT
);

  localparam logic [3:0] STARVE_LIMIT = 4'(CPU_STARVE_LIMIT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_VID_RD,
    S_VID_CAP,
    S_CPU_RD,
    S_CPU_CAP,
    S_CPU_WR
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  starve_q, starve_d;
  logic        cpu_done_q, cpu_done_d;
  logic [11:0] ram_addr_q, ram_addr_d;
  logic [15:0] ram_din_q, ram_din_d;
  logic        rd_n_q, rd_n_d;
  logic        wrh_n_q, wrh_n_d;
  logic        wrl_n_q, wrl_n_d;
  logic        vid_ack_q, vid_ack_d;
  logic        vid_valid_q, vid_valid_d;
  logic [15:0] vid_dout_q, vid_dout_d;
  logic [15:0] cpu_dout_q, cpu_dout_d;
  logic        dtack_n_q, dtack_n_d;

  // cpu_done blocks re-service of a REQ that is still held after DTACK; the
  // CPU must drop REQ for at least one edge before it can start again.
  logic cpu_pend;
  assign cpu_pend = i_CPU_REQ & ~cpu_done_q;

  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    cpu_done_d  = cpu_done_q;
    ram_addr_d  = ram_addr_q;
    ram_din_d   = ram_din_q;
    rd_n_d      = rd_n_q;
    wrh_n_d     = wrh_n_q;
    wrl_n_d     = wrl_n_q;
    vid_ack_d   = 1'b0;
    vid_valid_d = 1'b0;
    vid_dout_d  = vid_dout_q;
    cpu_dout_d  = cpu_dout_q;
    dtack_n_d   = dtack_n_q;

    // DTACK release runs independently of the access sequencer, so video
    // traffic does not delay the CPU seeing its acknowledge drop.
    if (cpu_done_q && !i_CPU_REQ) begin
      dtack_n_d  = 1'b1;
      cpu_done_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (!cpu_pend) begin
          starve_d = '0;
        end
        if (cpu_pend && ((starve_q == STARVE_LIMIT) || !i_VID_REQ)) begin
          starve_d   = '0;
          ram_addr_d = i_CPU_ADDR;
          if (i_CPU_WE) begin
            // Byte strobes map straight onto the half write strobes; with
            // both inactive the cycle still runs and DTACK is still given.
            ram_din_d = i_CPU_DIN;
            wrh_n_d   = i_CPU_UDS_n;
            wrl_n_d   = i_CPU_LDS_n;
            state_d   = S_CPU_WR;
          end else begin
            rd_n_d  = 1'b0;
            state_d = S_CPU_RD;
          end
        end else if (i_VID_REQ) begin
          ram_addr_d = i_VID_ADDR;
          rd_n_d     = 1'b0;
          vid_ack_d  = 1'b1;
          state_d    = S_VID_RD;
          if (cpu_pend && (starve_q != STARVE_LIMIT)) begin
            starve_d = starve_q + 4'd1;
          end
        end
      end
      S_VID_RD: begin
        rd_n_d  = 1'b1;
        state_d = S_VID_CAP;
      end
      S_VID_CAP: begin
        vid_dout_d  = i_RAM_DOUT;
        vid_valid_d = 1'b1;
        state_d     = S_IDLE;
      end
      S_CPU_RD: begin
        rd_n_d  = 1'b1;
        state_d = S_CPU_CAP;
      end
      S_CPU_CAP: begin
        // Full word is returned regardless of byte strobes; the 68000 picks
        // the byte lanes it asked for.
        cpu_dout_d = i_RAM_DOUT;
        dtack_n_d  = 1'b0;
        cpu_done_d = 1'b1;
        state_d    = S_IDLE;
      end
      S_CPU_WR: begin
        wrh_n_d    = 1'b1;
        wrl_n_d    = 1'b1;
        dtack_n_d  = 1'b0;
        cpu_done_d = 1'b1;
        state_d    = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Reset aborts any access in flight; nothing is retried and no VALID or
  // DTACK is produced for the aborted cycle.
  always_ff @(posedge i_MCLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      state_q     <= S_IDLE;
      starve_q    <= '0;
      cpu_done_q  <= 1'b0;
      ram_addr_q  <= '0;
      ram_din_q   <= '0;
      rd_n_q      <= 1'b1;
      wrh_n_q     <= 1'b1;
      wrl_n_q     <= 1'b1;
      vid_ack_q   <= 1'b0;
      vid_valid_q <= 1'b0;
      vid_dout_q  <= '0;
      cpu_dout_q  <= '0;
      dtack_n_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      cpu_done_q  <= cpu_done_d;
      ram_addr_q  <= ram_addr_d;
      ram_din_q   <= ram_din_d;
      rd_n_q      <= rd_n_d;
      wrh_n_q     <= wrh_n_d;
      wrl_n_q     <= wrl_n_d;
      vid_ack_q   <= vid_ack_d;
      vid_valid_q <= vid_valid_d;
      vid_dout_q  <= vid_dout_d;
      cpu_dout_q  <= cpu_dout_d;
      dtack_n_q   <= dtack_n_d;
    end
  end

  assign o_VID_ACK     = vid_ack_q;
  assign o_VID_DOUT    = vid_dout_q;
  assign o_VID_VALID   = vid_valid_q;
  assign o_CPU_DOUT    = cpu_dout_q;
  assign o_CPU_DTACK_n = dtack_n_q;
  assign o_RAM_ADDR    = ram_addr_q;
  assign o_RAM_DIN     = ram_din_q;
  assign o_RAM_WRH_n   = wrh_n_q;
  assign o_RAM_WRL_n   = wrl_n_q;
  assign o_RAM_RD_n    = rd_n_q;

endmodule

// File: tb/tb_vram1_access_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_vram1_access_arbiter
//
// Directed scenarios followed by randomized concurrent video/CPU traffic.
// A behavioural SRAM sits on the RAM port; ref_mem is a transaction-level
// image of what the array must contain, updated when a CPU write completes.
// A monitor predicts each video VALID/DOUT two cycles after ACK and tracks
// strobe pulse widths, strobe exclusivity and the number of SRAM accesses.
// -----------------------------------------------------------------------------
module tb_vram1_access_arbiter;

  localparam int LIMIT = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vid_req;
  logic [11:0] vid_addr;
  logic        vid_ack;
  logic [15:0] vid_dout;
  logic        vid_valid;
  logic        cpu_req;
  logic [11:0] cpu_addr;
  logic        cpu_we;
  logic        cpu_uds_n;
  logic        cpu_lds_n;
  logic [15:0] cpu_din;
  logic [15:0] cpu_dout;
  logic        dtack_n;
  logic [11:0] ram_addr;
  logic [15:0] ram_din;
  logic        ram_wrh_n;
  logic        ram_wrl_n;
  logic        ram_rd_n;
  logic [15:0] ram_dout = '0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  vram1_access_arbiter #(.CPU_STARVE_LIMIT(LIMIT)) dut (
    .i_MCLK        (clk),
    .i_RST_n       (rst_n),
    .i_VID_REQ     (vid_req),
    .i_VID_ADDR    (vid_addr),
    .o_VID_ACK     (vid_ack),
    .o_VID_DOUT    (vid_dout),
    .o_VID_VALID   (vid_valid),
    .i_CPU_REQ     (cpu_req),
    .i_CPU_ADDR    (cpu_addr),
    .i_CPU_WE      (cpu_we),
    .i_CPU_UDS_n   (cpu_uds_n),
    .i_CPU_LDS_n   (cpu_lds_n),
    .i_CPU_DIN     (cpu_din),
    .o_CPU_DOUT    (cpu_dout),
    .o_CPU_DTACK_n (dtack_n),
    .o_RAM_ADDR    (ram_addr),
    .o_RAM_DIN     (ram_din),
    .o_RAM_WRH_n   (ram_wrh_n),
    .o_RAM_WRL_n   (ram_wrl_n),
    .o_RAM_RD_n    (ram_rd_n),
    .i_RAM_DOUT    (ram_dout)
  );

  function automatic logic [15:0] init_word(input int i);
    if (i == 12'h123) return 16'hBEEF;
    if (i == 12'h456) return 16'h1234;
    return 16'((i * 40503) ^ 16'h5A5A);
  endfunction

  // Behavioural SRAM: strobe sampled low at an edge acts at that edge.
  logic [15:0] mem [4096];
  bit          preloaded = 1'b0;
  always @(posedge clk) begin
    if (!preloaded) begin
      for (int i = 0; i < 4096; i++) mem[i] <= init_word(i);
      preloaded <= 1'b1;
    end else begin
      if (!ram_rd_n)  ram_dout <= mem[ram_addr];
      if (!ram_wrh_n) mem[ram_addr][15:8] <= ram_din[15:8];
      if (!ram_wrl_n) mem[ram_addr][7:0]  <= ram_din[7:0];
    end
  end

  logic [15:0] ref_mem [4096];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  logic [11:0] vid_addr_s;
  int          vid_cd = 0;
  logic [15:0] vid_exp;
  int          wrh_run = 0, wrl_run = 0;
  int          wrh_total = 0, wrl_total = 0, ram_acc = 0;

  always @(posedge clk) vid_addr_s = vid_addr;

  always @(negedge clk) begin
    if (!rst_n) begin
      vid_cd  = 0;
      wrh_run = 0;
      wrl_run = 0;
    end else begin
      if (vid_cd > 0) begin
        vid_cd--;
        if (vid_cd == 0) begin
          check("vid_valid", vid_valid, 1);
          check("vid_dout", vid_dout, vid_exp);
          $display("vid read data=0x%04h", vid_dout);
        end else begin
          check("vid_valid_early", vid_valid, 0);
        end
      end else begin
        check("vid_valid_idle", vid_valid, 0);
      end
      if (vid_ack) begin
        vid_exp = ref_mem[vid_addr_s];
        vid_cd  = 2;
      end
      check("strobe_excl", (!ram_rd_n && (!ram_wrh_n || !ram_wrl_n)), 0);
      if (!ram_rd_n || !ram_wrh_n || !ram_wrl_n) ram_acc++;
      if (!ram_wrh_n) begin wrh_run++; wrh_total++; end
      else begin if (wrh_run > 0) check("wrh_pulse", wrh_run, 1); wrh_run = 0; end
      if (!ram_wrl_n) begin wrl_run++; wrl_total++; end
      else begin if (wrl_run > 0) check("wrl_pulse", wrl_run, 1); wrl_run = 0; end
    end
  end

  // ---------------- agents ----------------
  task automatic vid_read(input logic [11:0] a, output int cyc);
    bit got = 1'b0;
    @(negedge clk);
    vid_req  = 1'b1;
    vid_addr = a;
    cyc = 0;
    while (!got && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (vid_ack) got = 1'b1;
    end
    vid_req = 1'b0;
    check("vid_ack_seen", got, 1);
  endtask

  task automatic cpu_access(input logic we, input logic [11:0] a, input logic u, input logic l,
                            input logic [15:0] d, input int hold, output int nack);
    bit got = 1'b0;
    int cyc = 0;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_uds_n = u; cpu_lds_n = l; cpu_din = d;
    nack = 0;
    while (!got && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (vid_ack) nack++;
      if (!dtack_n) got = 1'b1;
    end
    check("cpu_dtack_seen", got, 1);
    if (got) begin
      if (we) begin
        if (!u) ref_mem[a][15:8] = d[15:8];
        if (!l) ref_mem[a][7:0]  = d[7:0];
      end else begin
        check("cpu_dout", cpu_dout, ref_mem[a]);
      end
      check("cpu_starve_bound", (nack <= LIMIT), 1);
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        check("cpu_dtack_hold", dtack_n, 0);
      end
    end
    $display("cpu we=%0d addr=0x%03h uds_n=%0d lds_n=%0d din=0x%04h dout=0x%04h vid_grants=%0d",
             we, a, u, l, d, cpu_dout, nack);
    cpu_req = 1'b0;
    @(negedge clk);
    check("cpu_dtack_release", dtack_n, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n, acc0, h0, l0;
    rst_n = 1'b0;
    vid_req = 1'b0; vid_addr = '0;
    cpu_req = 1'b0; cpu_addr = '0; cpu_we = 1'b0;
    cpu_uds_n = 1'b1; cpu_lds_n = 1'b1; cpu_din = '0;
    for (int i = 0; i < 4096; i++) ref_mem[i] = init_word(i);

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_rd_n", ram_rd_n, 1);
    check("rst_wrh_n", ram_wrh_n, 1);
    check("rst_wrl_n", ram_wrl_n, 1);
    check("rst_dtack_n", dtack_n, 1);
    check("rst_vid_ack", vid_ack, 0);
    check("rst_vid_valid", vid_valid, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_vid_dout", vid_dout, 0);
    check("rst_cpu_dout", cpu_dout, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Video read of 0x123 with fixed latency
    vid_read(12'h123, n);
    check("t2_ack_latency", n, 1);
    @(negedge clk);
    @(negedge clk);
    check("t2_valid", vid_valid, 1);
    check("t2_dout", vid_dout, 16'hBEEF);

    // Upper-byte write then full read
    h0 = wrh_total; l0 = wrl_total;
    cpu_access(1'b1, 12'h456, 1'b0, 1'b1, 16'hABCD, 3, n);
    check("t3_wrh_cycles", wrh_total - h0, 1);
    check("t3_wrl_cycles", wrl_total - l0, 0);
    cpu_access(1'b0, 12'h456, 1'b0, 1'b0, 16'h0000, 2, n);
    check("t3_read_merge", cpu_dout, 16'hAB34);

    // Asynchronous reset in the middle of a CPU write
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h007;
    cpu_uds_n = 1'b0; cpu_lds_n = 1'b0; cpu_din = 16'hDEAD;
    @(negedge clk);
    check("t1_wrh_active", ram_wrh_n, 0);
    #2 rst_n = 1'b0;
    #1;
    check("t1_wrh_n", ram_wrh_n, 1);
    check("t1_wrl_n", ram_wrl_n, 1);
    check("t1_rd_n", ram_rd_n, 1);
    check("t1_dtack_n", dtack_n, 1);
    check("t1_vid_ack", vid_ack, 0);
    check("t1_vid_valid", vid_valid, 0);
    check("t1_ram_addr", ram_addr, 0);
    check("t1_ram_din", ram_din, 0);
    check("t1_vid_dout", vid_dout, 0);
    check("t1_cpu_dout", cpu_dout, 0);
    cpu_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t1_no_dtack", dtack_n, 1);
    end
    vid_read(12'h007, n);          // monitor confirms the aborted write left 0x007 intact
    check("t1_idle_latency", n, 1);
    repeat (3) @(negedge clk);

    // Simultaneous requests: video first, CPU right after
    @(negedge clk);
    vid_req = 1'b1; vid_addr = 12'h020;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h030;
    @(negedge clk);
    check("t4_video_first", vid_ack, 1);
    check("t4_no_early_dtack", dtack_n, 1);
    vid_req = 1'b0;
    n = 0;
    while (dtack_n && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("t4_cpu_latency", n, 5);
    check("t4_cpu_dout", cpu_dout, ref_mem[12'h030]);
    cpu_req = 1'b0;
    @(negedge clk);
    check("t4_dtack_release", dtack_n, 1);
    repeat (3) @(negedge clk);

    // Starvation bound with video held continuously
    @(negedge clk);
    vid_req = 1'b1; vid_addr = 12'h040;
    cpu_access(1'b0, 12'h041, 1'b0, 1'b0, 16'h0, 0, n);
    check("t5_starve_grants", n, LIMIT);
    cpu_access(1'b0, 12'h042, 1'b0, 1'b0, 16'h0, 0, n);
    check("t5_starve_regrants", n, LIMIT);
    vid_req = 1'b0;
    repeat (4) @(negedge clk);

    // REQ held after DTACK is serviced exactly once
    acc0 = ram_acc;
    cpu_access(1'b0, 12'h050, 1'b0, 1'b0, 16'h0, 20, n);
    check("t6_single_access", ram_acc - acc0, 1);
    cpu_access(1'b0, 12'h051, 1'b0, 1'b0, 16'h0, 0, n);
    check("t6_second_access", ram_acc - acc0, 2);

    // Randomized concurrent traffic on a small address window
    fork
      begin
        int c;
        for (int k = 0; k < 60; k++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          vid_read(12'($urandom_range(0, 15)), c);
        end
      end
      begin
        int g;
        for (int k = 0; k < 60; k++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          cpu_access(1'($urandom_range(0, 1)), 12'($urandom_range(0, 15)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     16'($urandom), $urandom_range(0, 3), g);
        end
      end
    join
    repeat (5) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
